// File: rtl/obj_pkg.sv
// Shared definitions for the object scan scheduler.
// Contents:
//   state_e  - FSM state encoding: IDLE, SETTLE, TRIGGER, WAIT_ECHO, UPDATE
//   SEL_*    - ranger mux encodings (left/right/front; 2'b11 is never driven)
//   next_sel - round-robin successor left -> right -> front -> left
package obj_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    TRIGGER,
    WAIT_ECHO,
    UPDATE
  } state_e;

  localparam logic [1:0] SEL_LEFT  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_FRONT = 2'b10;

  function automatic logic [1:0] next_sel(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      SEL_LEFT:  nxt = SEL_RIGHT;
      SEL_RIGHT: nxt = SEL_FRONT;
      default:   nxt = SEL_LEFT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/obj_cycle_timer.sv
// Loadable down-counter shared by the timed scheduler states.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-low reset (count -> 0)
//   load     - load load_val this edge (takes priority over counting)
//   load_val - cycle count for the state being entered
//   done     - high in the last cycle of the loaded interval (count == 1)
module obj_cycle_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A state entered with value N sees N, N-1, ..., 1; the final cycle is count 1.
  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/obj_scan_scheduler.sv
// Round-robin scheduler for one ultrasonic ranger shared across three
// directions. Per direction: settle the mux, pulse the trigger, wait for
// an echo (or time out), then latch the result for that direction.
// Ports:
//   clk, reset (sync, active-low), enable (scan permitted)
//   echo_valid, echo_near          - ranger result, sampled in WAIT_ECHO only
//   sel                            - ranger mux select (00 L, 01 R, 10 F)
//   trig                           - trigger pulse, high throughout TRIGGER
//   busy                           - high outside IDLE
//   left/right/front_object_detected - latched per-direction results
//   scan_done                      - one-cycle pulse on the front UPDATE
//   timeout_err                    - one-cycle pulse on a timed-out UPDATE
// All parameters must be >= 1.
module obj_scan_scheduler
  import obj_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TRIG_CYCLES    = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       echo_valid,
  input  logic       echo_near,
  output logic [1:0] sel,
  output logic       trig,
  output logic       busy,
  output logic       left_object_detected,
  output logic       right_object_detected,
  output logic       front_object_detected,
  output logic       scan_done,
  output logic       timeout_err
);

  localparam int MAX_ST = (SETTLE_CYCLES > TRIG_CYCLES) ? SETTLE_CYCLES : TRIG_CYCLES;
  localparam int MAX_C  = (MAX_ST > TIMEOUT_CYCLES) ? MAX_ST : TIMEOUT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] LD_SETTLE  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] LD_TRIG    = CNT_W'(TRIG_CYCLES);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [2:0]       det_q, det_d;   // bit 0 left, bit 1 right, bit 2 front
  logic             near_q, near_d;
  logic             tmo_q, tmo_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  obj_cycle_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    det_d    = det_q;
    near_d   = near_q;
    tmo_d    = tmo_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
          tmr_val  = LD_SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_done) begin
          state_d  = TRIGGER;
          tmr_load = 1'b1;
          tmr_val  = LD_TRIG;
        end
      end
      TRIGGER: begin
        if (tmr_done) begin
          state_d  = WAIT_ECHO;
          tmr_load = 1'b1;
          tmr_val  = LD_TIMEOUT;
        end
      end
      WAIT_ECHO: begin
        // Echo is tested first so an echo in the final wait cycle still counts.
        if (echo_valid) begin
          state_d = UPDATE;
          near_d  = echo_near;
          tmo_d   = 1'b0;
        end else if (tmr_done) begin
          state_d = UPDATE;
          near_d  = 1'b0;
          tmo_d   = 1'b1;
        end
      end
      UPDATE: begin
        case (sel_q)
          SEL_LEFT:  det_d[0] = tmo_q ? 1'b0 : near_q;
          SEL_RIGHT: det_d[1] = tmo_q ? 1'b0 : near_q;
          default:   det_d[2] = tmo_q ? 1'b0 : near_q;
        endcase
        sel_d = next_sel(sel_q);
        if (enable) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
          tmr_val  = LD_SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= SEL_LEFT;
      det_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      det_q   <= det_d;
      tmo_q   <= tmo_d;
    end
  end

  // Captured echo result; only consumed in UPDATE, which reset cannot reach
  // without passing WAIT_ECHO first.
  always_ff @(posedge clk) begin
    near_q <= near_d;
  end

  assign sel                   = sel_q;
  assign trig                  = (state_q == TRIGGER);
  assign busy                  = (state_q != IDLE);
  assign scan_done             = (state_q == UPDATE) && (sel_q == SEL_FRONT);
  assign timeout_err           = (state_q == UPDATE) && tmo_q;
  assign left_object_detected  = det_q[0];
  assign right_object_detected = det_q[1];
  assign front_object_detected = det_q[2];

endmodule

// File: tb/tb_obj_scan_scheduler.sv
// Bench for obj_scan_scheduler with default parameters. Each measurement is
// described by its echo offset within the wait window; expected outputs are
// derived from the cycle arithmetic S / S+T / S+T+wait, and the expected
// direction and flags advance once per completed measurement.
module tb_obj_scan_scheduler;

  localparam int S  = 4;
  localparam int T  = 10;
  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       reset, enable, echo_valid, echo_near;
  logic [1:0] sel;
  logic       trig, busy, scan_done, timeout_err;
  logic       left_object_detected, right_object_detected, front_object_detected;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_sel;
  logic exp_flag [3];

  obj_scan_scheduler dut (
    .clk                   (clk),
    .reset                 (reset),
    .enable                (enable),
    .echo_valid            (echo_valid),
    .echo_near             (echo_near),
    .sel                   (sel),
    .trig                  (trig),
    .busy                  (busy),
    .left_object_detected  (left_object_detected),
    .right_object_detected (right_object_detected),
    .front_object_detected (front_object_detected),
    .scan_done             (scan_done),
    .timeout_err           (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic b, input logic t,
                         input logic sd, input logic te);
    chk({tag, ".sel"},   32'(sel),                   32'(exp_sel));
    chk({tag, ".busy"},  32'(busy),                  32'(b));
    chk({tag, ".trig"},  32'(trig),                  32'(t));
    chk({tag, ".done"},  32'(scan_done),             32'(sd));
    chk({tag, ".tmo"},   32'(timeout_err),           32'(te));
    chk({tag, ".left"},  32'(left_object_detected),  32'(exp_flag[0]));
    chk({tag, ".right"}, 32'(right_object_detected), 32'(exp_flag[1]));
    chk({tag, ".front"}, 32'(front_object_detected), 32'(exp_flag[2]));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic noise;
    echo_valid = 1'($urandom_range(0, 1));
    echo_near  = 1'($urandom_range(0, 1));
  endtask

  // Called in the cycle that decides SETTLE entry (IDLE or UPDATE with enable=1).
  // echo_off = wait cycle (1..TO) carrying echo_valid, 0 = no echo (timeout).
  // Returns in the UPDATE cycle with enable set to en_next.
  task automatic meas(input string tag, input int echo_off, input logic near,
                      input int drop_k, input logic en_next);
    int   upd_k;
    logic tmo;
    tmo   = (echo_off == 0);
    upd_k = S + T + (tmo ? TO : echo_off) + 1;
    for (int k = 1; k <= upd_k; k++) begin
      tick;
      if (k <= S)              chk_all({tag, ".settle"}, 1'b1, 1'b0, 1'b0, 1'b0);
      else if (k <= S + T)     chk_all({tag, ".trig"},   1'b1, 1'b1, 1'b0, 1'b0);
      else if (k < upd_k)      chk_all({tag, ".wait"},   1'b1, 1'b0, 1'b0, 1'b0);
      else                     chk_all({tag, ".update"}, 1'b1, 1'b0, exp_sel == 2, tmo);
      if (k > S + T && k < upd_k) begin
        echo_valid = ((k - (S + T)) == echo_off);
        echo_near  = echo_valid ? near : 1'($urandom_range(0, 1));
      end else begin
        noise;
      end
      if (k == drop_k) enable = 1'b0;
      if (k == upd_k)  enable = en_next;
    end
    exp_flag[exp_sel] = tmo ? 1'b0 : near;
    exp_sel = (exp_sel + 1) % 3;
  endtask

  initial begin
    exp_sel = 0;
    for (int i = 0; i < 3; i++) exp_flag[i] = 1'b0;

    // Reset held with enable and echo_valid asserted: reset must dominate.
    reset = 1'b0; enable = 1'b1; echo_valid = 1'b1; echo_near = 1'b1;
    repeat (3) begin
      tick;
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Cycle 0: reset released, enable=1.
    reset = 1'b1; enable = 1'b1; noise;
    meas("left_echo3", 3, 1'b1, 0, 1'b1);
    meas("right_r1", int'($urandom_range(1, 50)), 1'b0, 0, 1'b1);
    meas("front_r1", int'($urandom_range(1, 50)), 1'b1, 0, 1'b1);
    // Left was 1; a timeout must clear it.
    meas("left_tmo", 0, 1'b1, 0, 1'b1);
    meas("right_rnd", int'($urandom_range(1, 60)), 1'($urandom_range(0, 1)), 0, 1'b1);
    meas("front_rnd", int'($urandom_range(1, 60)), 1'($urandom_range(0, 1)), 0, 1'b1);
    // Echo in the very last wait cycle takes the echo path.
    meas("left_last", TO, 1'b1, 0, 1'b1);
    // Enable dropped during TRIGGER: measurement still completes, then IDLE.
    meas("right_drop", int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), S + 2, 1'b0);

    repeat (6) begin
      tick;
      chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);
      noise;
    end

    // Resume at the next direction (front).
    enable = 1'b1;
    meas("front_resume", int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), 0, 1'b1);

    // Next measurement (left) is interrupted by reset in WAIT_ECHO.
    for (int k = 1; k <= S + T + 5; k++) begin
      tick;
      echo_valid = 1'b0;
      echo_near  = 1'($urandom_range(0, 1));
    end
    reset = 1'b0; echo_valid = 1'b1; enable = 1'b1;
    exp_sel = 0;
    for (int i = 0; i < 3; i++) exp_flag[i] = 1'b0;
    tick;
    chk_all("rst_mid_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    chk_all("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; enable = 1'b0; echo_valid = 1'b0;
    tick;
    chk_all("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/obj_scan_scheduler.md
OBJ_SCAN_SCHEDULER -- requirements
Module: obj_scan_scheduler

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, giving the mux-settle cycles after sel changes and before trigger.
REQ-002 The block SHALL have parameter TRIG_CYCLES, default 10, giving the trigger pulse width in cycles.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, giving the maximum echo wait in cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: scanning permitted while high.
REQ-007 The block SHALL have port echo_valid, input, 1 bit: the shared ranger's measurement is complete this cycle.
REQ-008 The block SHALL have port echo_near, input, 1 bit: the measured object is within threshold; qualified by echo_valid.
REQ-009 The block SHALL have port sel, output, 2 bits: steers the shared ranger; 00 = left, 01 = right, 10 = front; 11 is never driven.
REQ-010 The block SHALL have port trig, output, 1 bit: ranger trigger pulse.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have ports left_object_detected, right_object_detected and front_object_detected, each output, 1 bit: latched per-direction results.
REQ-013 The block SHALL have port scan_done, output, 1 bit: one-cycle pulse when the front result is written.
REQ-014 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a measurement times out.

Function
REQ-015 The block SHALL be a Moore FSM with the states IDLE, SETTLE, TRIGGER, WAIT_ECHO and UPDATE.
REQ-016 From IDLE, with enable=1 sampled, the block SHALL move to SETTLE on the next edge; otherwise it SHALL stay in IDLE.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then the block SHALL move to TRIGGER.
REQ-018 TRIGGER SHALL last exactly TRIG_CYCLES cycles, then the block SHALL move to WAIT_ECHO.
REQ-019 trig SHALL be 1 exactly in the TRIGGER cycles and 0 in all other cycles.
REQ-020 In WAIT_ECHO, echo_valid=1 SHALL move the block to UPDATE on the next edge (echo path), capturing echo_near.
REQ-021 If TIMEOUT_CYCLES WAIT_ECHO cycles elapse with no echo_valid, the block SHALL move to UPDATE (timeout path).
REQ-022 If echo_valid=1 in the final WAIT_ECHO cycle, the echo path SHALL win over the timeout path.
REQ-023 echo_valid and echo_near SHALL be ignored in every state except WAIT_ECHO.
REQ-024 UPDATE SHALL last one cycle and SHALL write the flag selected by sel: the captured echo_near on the echo path, 0 on the timeout path.
REQ-025 The detection flags of the other two directions SHALL hold their values.
REQ-026 A written flag SHALL be visible 2 cycles after the cycle in which echo_valid=1.
REQ-027 timeout_err SHALL pulse during UPDATE on the timeout path only.
REQ-028 scan_done SHALL pulse during UPDATE when sel=10, on either path.
REQ-029 On leaving UPDATE, sel SHALL advance left -> right -> front -> left (wrap-around).
REQ-030 On leaving UPDATE, the block SHALL go to SETTLE if enable=1, else to IDLE.
REQ-031 sel SHALL change only on UPDATE exit and on reset.
REQ-032 Deasserting enable mid-measurement SHALL NOT abort the measurement: the current direction completes, then the block goes to IDLE.
REQ-033 sel SHALL be retained in IDLE so that the next enable resumes at the next direction.
REQ-034 One shared down-counter SHALL time SETTLE, TRIGGER and WAIT_ECHO, sized $clog2(max(SETTLE_CYCLES, TRIG_CYCLES, TIMEOUT_CYCLES)+1) bits and reloaded on each state entry.
REQ-035 All parameters SHALL be >= 1.

Reset
REQ-036 When reset=0 at a rising edge: the state SHALL be IDLE; sel SHALL be 00; trig, busy, scan_done and timeout_err SHALL be 0; all three detection flags SHALL be 0; the counter SHALL be 0.
REQ-037 Reset in any state, including mid-TRIGGER, SHALL take effect at that edge, with trig low the following cycle.
REQ-038 Reset SHALL override enable and echo_valid.

Structure
REQ-039 Shared package obj_pkg SHALL hold the state enum and the sel encodings SEL_LEFT=2'b00, SEL_RIGHT=2'b01 and SEL_FRONT=2'b10.
REQ-040 The counter SHALL be sub-module obj_cycle_timer, with inputs load and load_val and output done, instantiated once.

Verification
REQ-041 A bench SHALL cover: reset released, enable=1 at cycle 0 -> sel=00; trig high in cycles 5..14 (defaults); busy=1 from cycle 1.
REQ-042 A bench SHALL cover: echo_valid=1 with echo_near=1 at WAIT_ECHO cycle 3 for left -> left_object_detected=1 two cycles later; sel=01; right and front flags unchanged.
REQ-043 A bench SHALL cover: full L/R/F rounds with echo_near=1,0,1 -> flags 1,0,1; one scan_done pulse per round; sel wraps to 00.
REQ-044 A bench SHALL cover: no echo_valid for 1000 WAIT_ECHO cycles, with the flag previously 1 -> flag=0 and a single timeout_err pulse.
REQ-045 A bench SHALL cover: echo_valid=1 in the 1000th WAIT_ECHO cycle -> echo path taken and no timeout_err.
REQ-046 A bench SHALL cover: enable dropped during TRIGGER -> measurement completes, IDLE, busy=0, sel retained. A bench SHALL also cover reset=0 mid-WAIT_ECHO -> all outputs 0 on the next cycle.
